// File: rtl/fe_req_ctl.sv
// Front-end request controller: latches per-device request lines into a pending
// register and exposes pending/enable/ack/mode to the HPS over Avalon-MM.
module fe_req_ctl #(
  parameter int N = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_in,
  input  logic [1:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic [31:0]   fe_req,
  output logic          irq
);

  typedef enum logic [1:0] {
    ADDR_PENDING = 2'd0,
    ADDR_ENABLE  = 2'd1,
    ADDR_ACK     = 2'd2,
    ADDR_MODE    = 2'd3
  } reg_addr_e;

  logic [N-1:0] pending;
  logic [N-1:0] enable;
  logic [N-1:0] mode;
  logic [N-1:0] req_d;

  logic [N-1:0] rise;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] active;
  logic [31:0]  read_mux;

  reg_addr_e addr;
  assign addr = reg_addr_e'(avs_address);

  // Level-mode channels re-set every cycle the line is high, so an ACK only
  // sticks once the line has dropped; set is ORed last so it wins over clear.
  assign rise        = req_in & ~req_d;
  assign set_mask    = (mode & req_in) | (~mode & rise);
  assign clr_mask    = (avs_write && addr == ADDR_ACK) ? avs_writedata[N-1:0] : '0;
  assign pending_nxt = (pending & ~clr_mask) | set_mask;
  assign active      = pending & enable;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    read_mux = '0;
    unique case (addr)
      ADDR_PENDING: read_mux[N-1:0] = pending;
      ADDR_ENABLE:  read_mux[N-1:0] = enable;
      ADDR_ACK:     read_mux        = '0;
      ADDR_MODE:    read_mux[N-1:0] = mode;
    endcase
  end

  always_comb begin
    fe_req         = '0;
    fe_req[N-1:0]  = active;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; this is what makes a same-cycle read return the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending      <= '0;
      enable       <= '0;
      mode         <= '0;
      req_d        <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      req_d   <= req_in;
      pending <= pending_nxt;
      irq     <= |active;
      if (avs_write && addr == ADDR_ENABLE) enable <= avs_writedata[N-1:0];
      if (avs_write && addr == ADDR_MODE)   mode   <= avs_writedata[N-1:0];
      if (avs_read)                         avs_readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_fe_req_ctl.sv
// Directed bench for fe_req_ctl: reads are scoreboarded through a queue popped
// by a monitor one cycle after each read strobe; fe_req/irq are sampled directly.
module tb_fe_req_ctl;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_in;
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [31:0]   fe_req;
  logic          irq;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic read_q = 1'b0;

  fe_req_ctl #(.N(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_in        (req_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .fe_req        (fe_req),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: readdata is valid the cycle after a read strobe.
  always @(posedge clk) read_q <= avs_read && reset_n;

  always @(negedge clk) begin
    if (read_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%0h, want no read", avs_readdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, avs_readdata, e.data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    cyc(1);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back('{name: name, data: exp});
    avs_address = a;
    avs_read    = 1'b1;
    cyc(1);
    avs_read    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_in = '0; avs_address = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    cyc(2);
    check("rst_fe_req", fe_req, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    cyc(1);

    // Pulse on channel 1 latches with enable off.
    req_in = 3'b010; cyc(1); req_in = 3'b000;
    check("pulse_fe_req_masked", fe_req, 32'h0);
    check("pulse_irq_masked", {31'b0, irq}, 32'h0);
    rd(2'd0, 32'h2, "pulse_pending");

    // Enable all, rise on channel 0.
    wr(2'd2, 32'h2);
    wr(2'd1, 32'h7);
    check("en_fe_req_idle", fe_req, 32'h0);
    req_in = 3'b001; cyc(1);
    check("rise0_fe_req", fe_req, 32'h1);
    check("rise0_irq_not_yet", {31'b0, irq}, 32'h0);
    cyc(1);
    check("rise0_irq", {31'b0, irq}, 32'h1);
    rd(2'd0, 32'h1, "rise0_pending_read");

    // Edge mode: held line pends once.
    req_in = 3'b101; cyc(1);
    check("edge_set", fe_req, 32'h5);
    wr(2'd2, 32'h4);
    check("edge_ack", fe_req, 32'h1);
    cyc(3);
    check("edge_held_clear", fe_req, 32'h1);
    req_in = 3'b001; cyc(1);
    req_in = 3'b101; cyc(1);
    check("edge_repend", fe_req, 32'h5);

    // Level mode: ACK while high does not stick.
    wr(2'd3, 32'h4);
    wr(2'd2, 32'h4);
    check("level_ack_high", fe_req, 32'h5);
    req_in = 3'b001; cyc(1);
    check("level_dropped_held", fe_req, 32'h5);
    wr(2'd2, 32'h5);
    check("level_ack_low", fe_req, 32'h0);
    check("level_irq_old", {31'b0, irq}, 32'h1);
    cyc(1);
    check("level_irq_clear", {31'b0, irq}, 32'h0);

    // Set wins over same-cycle clear.
    req_in = 3'b000; cyc(1);
    req_in = 3'b001; cyc(1);
    req_in = 3'b000; cyc(1);
    req_in = 3'b001;
    wr(2'd2, 32'h1);
    check("set_wins", fe_req, 32'h1);
    rd(2'd2, 32'h0, "ack_reads_zero");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h7, "enable_width");
    rd(2'd3, 32'h4, "mode_read");
    wr(2'd0, 32'h7);
    rd(2'd0, 32'h1, "pending_ro");

    // Read and write to ENABLE in one cycle returns the old value.
    exp_q.push_back('{name: "rw_same_old", data: 32'h7});
    avs_address = 2'd1; avs_writedata = 32'h2;
    avs_read = 1'b1; avs_write = 1'b1;
    cyc(1);
    avs_read = 1'b0; avs_write = 1'b0;
    rd(2'd1, 32'h2, "rw_same_new");
    check("enable_masks", fe_req, 32'h0);

    // Reset mid-operation.
    wr(2'd1, 32'h7);
    req_in = 3'b111; cyc(1);
    check("all_pending", fe_req, 32'h7);
    cyc(1);
    check("all_irq", {31'b0, irq}, 32'h1);
    req_in = 3'b001;
    reset_n = 1'b0; cyc(1);
    check("midrst_fe_req", fe_req, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1; cyc(1);
    rd(2'd0, 32'h1, "post_rst_repend");
    cyc(3);
    check("readdata_hold", avs_readdata, 32'h1);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
